// File: rtl/uart_rom_loader.sv
// uart_rom_loader: receives an 8N1 UART image, writes 32-bit words to the ROM and releases core reset on a good checksum.
module uart_rom_loader #(
  parameter int CLK_FREQ = 50_000_000,
  parameter int BAUD     = 115_200,
  parameter int ADDR_W   = 12
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              uart_rx_i,
  output logic              rom_we_o,
  output logic [ADDR_W-1:0] rom_waddr_o,
  output logic [31:0]       rom_wdata_o,
  output logic              core_rst_n_o,
  output logic              load_busy_o,
  output logic              load_done_o,
  output logic              load_err_o
);
  localparam int CPB = CLK_FREQ / BAUD;
  localparam int CW = $clog2(CPB + 1);
  localparam logic [16:0] MAX_N = 17'(2 ** ADDR_W);
  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_t;
  typedef enum logic [2:0] {IDLE, LEN0, LEN1, DATA, CSUM, DONE, ERR} st_t;
  rx_t rx_st;
  st_t st, nxt;
  logic [1:0] sync;
  logic [CW-1:0] cnt;
  logic [2:0] bit_cnt;
  logic [7:0] sh, len_lo, csum;
  logic [15:0] n_words, wcnt;
  logic [1:0] bc;
  logic [23:0] wbuf;
  logic rx, stop_tick, byte_stb, frm_err;
  logic [16:0] n_rx;
  assign rx = sync[1];
  assign stop_tick = (rx_st == RX_STOP) && (cnt == CW'(CPB - 1));
  assign byte_stb = stop_tick && rx;
  assign frm_err = stop_tick && !rx;
  assign n_rx = {1'b0, sh, len_lo};
  // sync resets high so the idle line never looks like a start bit
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync <= 2'b11;
      rx_st <= RX_IDLE;
      cnt <= '0;
      bit_cnt <= '0;
      sh <= '0;
    end else begin
      sync <= {sync[0], uart_rx_i};
      case (rx_st)
        RX_IDLE: begin
          cnt <= '0;
          if (!rx) rx_st <= RX_START;
        end
        RX_START: if (cnt == CW'(CPB / 2 - 1)) begin
          cnt <= '0;
          bit_cnt <= '0;
          rx_st <= rx ? RX_IDLE : RX_DATA;
        end else cnt <= cnt + 1'b1;
        RX_DATA: if (cnt == CW'(CPB - 1)) begin
          cnt <= '0;
          sh <= {rx, sh[7:1]};
          bit_cnt <= bit_cnt + 1'b1;
          if (bit_cnt == 3'd7) rx_st <= RX_STOP;
        end else cnt <= cnt + 1'b1;
        RX_STOP: if (stop_tick) begin
          cnt <= '0;
          rx_st <= RX_IDLE;
        end else cnt <= cnt + 1'b1;
      endcase
    end
  end
  always_comb begin
    nxt = st;
    if (frm_err) nxt = ERR;
    else if (byte_stb)
      case (st)
        IDLE, DONE, ERR: nxt = (sh == 8'hA5) ? LEN0 : st;
        LEN0: nxt = LEN1;
        LEN1: nxt = (n_rx > MAX_N) ? ERR : (n_rx == 17'd0) ? CSUM : DATA;
        DATA: nxt = (bc == 2'd3 && wcnt + 16'd1 == n_words) ? CSUM : DATA;
        CSUM: nxt = (sh == csum) ? DONE : ERR;
        default: nxt = ERR;
      endcase
  end
  // outputs are registered from the next state so they change with it
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st <= IDLE;
      rom_we_o <= 1'b0;
      rom_waddr_o <= '0;
      rom_wdata_o <= '0;
      core_rst_n_o <= 1'b0;
      load_busy_o <= 1'b0;
      load_done_o <= 1'b0;
      load_err_o <= 1'b0;
      len_lo <= '0;
      csum <= '0;
      n_words <= '0;
      wcnt <= '0;
      bc <= '0;
      wbuf <= '0;
    end else begin
      st <= nxt;
      load_busy_o <= nxt inside {LEN0, LEN1, DATA, CSUM};
      load_done_o <= nxt == DONE;
      core_rst_n_o <= nxt == DONE;
      load_err_o <= nxt == ERR;
      rom_we_o <= 1'b0;
      if (byte_stb)
        case (st)
          LEN0: begin
            len_lo <= sh;
            csum <= sh;
          end
          LEN1: begin
            n_words <= {sh, len_lo};
            csum <= csum ^ sh;
            wcnt <= '0;
            bc <= '0;
          end
          DATA: begin
            csum <= csum ^ sh;
            bc <= bc + 1'b1;
            wbuf <= {sh, wbuf[23:8]};
            if (bc == 2'd3) begin
              rom_we_o <= 1'b1;
              rom_waddr_o <= wcnt[ADDR_W-1:0];
              rom_wdata_o <= {sh, wbuf};
              wcnt <= wcnt + 16'd1;
            end
          end
          default: ;
        endcase
    end
  end
endmodule

// File: tb/tb_uart_rom_loader.sv
// tb_uart_rom_loader: directed UART frames against a word/checksum model and a write scoreboard.
module tb_uart_rom_loader;
  localparam int CLK_FREQ = 1_600_000;
  localparam int BAUD = 100_000;
  localparam int CPB = 16;
  localparam int ADDR_W = 12;
  logic clk = 1'b0, rst_n = 1'b0, rx = 1'b1;
  logic rom_we, core_rst_n, busy, done, err;
  logic [ADDR_W-1:0] waddr;
  logic [31:0] wdata;
  int checks = 0, errors = 0;
  logic [31:0] img[$];
  logic [43:0] exp_q[$];
  logic we_d = 1'b0;

  uart_rom_loader #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst_n(rst_n), .uart_rx_i(rx), .rom_we_o(rom_we), .rom_waddr_o(waddr),
    .rom_wdata_o(wdata), .core_rst_n_o(core_rst_n), .load_busy_o(busy),
    .load_done_o(done), .load_err_o(err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", name, act, exp);
    end
  endtask

  task automatic status(input string name, input logic b, input logic d, input logic e);
    chk({name, "_busy"}, {31'b0, busy}, {31'b0, b});
    chk({name, "_done"}, {31'b0, done}, {31'b0, d});
    chk({name, "_err"}, {31'b0, err}, {31'b0, e});
    chk({name, "_core"}, {31'b0, core_rst_n}, {31'b0, d});
  endtask

  function automatic logic [7:0] model_csum(input int n);
    logic [7:0] c;
    c = n[7:0] ^ n[15:8];
    for (int k = 0; k < n; k++)
      for (int j = 0; j < 4; j++) c ^= img[k][8*j+:8];
    return c;
  endfunction

  task automatic send_byte(input logic [7:0] b, input logic stop);
    rx = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (CPB) @(negedge clk);
    end
    rx = stop;
    repeat (CPB) @(negedge clk);
    rx = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic send_frame(input int n, input logic [7:0] cs);
    send_byte(8'hA5, 1'b1);
    send_byte(n[7:0], 1'b1);
    send_byte(n[15:8], 1'b1);
    for (int k = 0; k < n; k++) begin
      exp_q.push_back({12'(k), img[k]});
      for (int j = 0; j < 4; j++) send_byte(img[k][8*j+:8], 1'b1);
    end
    send_byte(cs, 1'b1);
    repeat (4) @(negedge clk);
  endtask

  // every write must be a single-cycle pulse matching the next expected word
  always @(negedge clk) begin
    if (rst_n && rom_we) begin
      chk("we_single", {31'b0, we_d}, 32'd0);
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_write addr %h data %h", waddr, wdata);
      end else begin
        logic [43:0] e;
        e = exp_q.pop_front();
        chk("waddr", {20'b0, waddr}, {20'b0, e[43:32]});
        chk("wdata", wdata, e[31:0]);
      end
    end
    we_d = rst_n && rom_we;
  end

  initial begin
    repeat (3) @(negedge clk);
    status("reset", 1'b0, 1'b0, 1'b0);
    chk("reset_we", {31'b0, rom_we}, 32'd0);
    chk("reset_addr", {20'b0, waddr}, 32'd0);
    chk("reset_data", wdata, 32'd0);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);

    img = '{32'h0000_0013, 32'h0010_0093};
    chk("csum_model_t1", {24'b0, model_csum(2)}, 32'h92);
    send_frame(2, model_csum(2));
    status("t1", 1'b0, 1'b1, 1'b0);
    chk("t1_drained", exp_q.size(), 32'd0);

    send_byte(8'h00, 1'b1);
    send_byte(8'hFF, 1'b1);
    send_byte(8'h5A, 1'b1);
    status("t3_noise", 1'b0, 1'b1, 1'b0);
    img = '{32'h0000_006F};
    chk("csum_model_t3", {24'b0, model_csum(1)}, 32'h6E);
    send_frame(1, 8'h6E);
    status("t3", 1'b0, 1'b1, 1'b0);

    img = '{32'h0000_0013, 32'h0010_0093};
    send_frame(2, 8'h00);
    status("t2", 1'b0, 1'b0, 1'b1);
    chk("t2_drained", exp_q.size(), 32'd0);

    send_byte(8'hA5, 1'b1);
    send_byte(8'h01, 1'b1);
    send_byte(8'h00, 1'b1);
    send_byte(8'h6F, 1'b1);
    send_byte(8'h00, 1'b0);
    repeat (40) @(negedge clk);
    status("t4_err", 1'b0, 1'b0, 1'b1);
    img = '{32'h1234_5678};
    send_frame(1, model_csum(1));
    status("t4_recover", 1'b0, 1'b1, 1'b0);

    send_byte(8'hA5, 1'b1);
    send_byte(8'h01, 1'b1);
    send_byte(8'h10, 1'b1);
    repeat (4) @(negedge clk);
    status("t5_len", 1'b0, 1'b0, 1'b1);

    exp_q.push_back({12'd0, 32'h0000_006F});
    send_byte(8'hA5, 1'b1);
    send_byte(8'h01, 1'b1);
    send_byte(8'h00, 1'b1);
    rx = 1'b0;
    repeat (CPB / 4) @(negedge clk);
    rx = 1'b1;
    repeat (40) @(negedge clk);
    send_byte(8'h6F, 1'b1);
    send_byte(8'h00, 1'b1);
    send_byte(8'h00, 1'b1);
    send_byte(8'h00, 1'b1);
    send_byte(8'h6E, 1'b1);
    repeat (4) @(negedge clk);
    status("glitch", 1'b0, 1'b1, 1'b0);
    chk("glitch_drained", exp_q.size(), 32'd0);

    send_byte(8'hA5, 1'b1);
    status("t6_reload", 1'b1, 1'b0, 1'b0);
    send_byte(8'h02, 1'b1);
    send_byte(8'h00, 1'b1);
    send_byte(8'h13, 1'b1);
    send_byte(8'h00, 1'b1);
    rst_n = 1'b0;
    #1;
    status("t6_rst", 1'b0, 1'b0, 1'b0);
    chk("t6_rst_we", {31'b0, rom_we}, 32'd0);
    chk("t6_rst_addr", {20'b0, waddr}, 32'd0);
    chk("t6_rst_data", wdata, 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    send_byte(8'h00, 1'b1);
    send_byte(8'h00, 1'b1);
    send_byte(8'h93, 1'b1);
    send_byte(8'h00, 1'b1);
    send_byte(8'h10, 1'b1);
    send_byte(8'h00, 1'b1);
    send_byte(8'h92, 1'b1);
    repeat (4) @(negedge clk);
    status("t6_after", 1'b0, 1'b0, 1'b0);
    chk("final_drained", exp_q.size(), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
